// File: rtl/i_block_mem.sv
// i_block_mem: block-refill instruction memory with programmable latency and word program port.
// Define I_MEM_LAST_BLOCK_EN to add a one-entry last-block buffer for single-cycle repeat hits.
module i_block_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [27:0]  ADDRESS,
  input  logic         READ,
  output logic [127:0] READDATA,
  output logic         BUSYWAIT,
  input  logic         PROG_WE,
  input  logic [31:0]  PROG_ADDR,
  input  logic [31:0]  PROG_DATA
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q;
  logic [7:0] cnt_q;
  logic [27:0] addr_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] blk_w;
  logic [AW-1:0] base;
  logic [AW-1:0] prog_idx;
  logic [127:0] blk_rd;
  logic complete;
  logic hit;
  logic [127:0] lb_rd;
  logic unused_bits;
  assign blk_w = {addr_q, 2'b00};
  assign base = blk_w[AW-1:0];
  assign prog_idx = PROG_ADDR[AW+1:2];
  assign blk_rd = {mem[base | AW'(3)], mem[base | AW'(2)], mem[base | AW'(1)], mem[base]};
  assign complete = state_q == WAIT && cnt_q == 8'd0;
  assign unused_bits = ^{PROG_ADDR[31:AW+2], PROG_ADDR[1:0], blk_w[29:AW]};
  // Reads sample the array before this edge's write, so a same-edge write returns the old word
  always_ff @(posedge CLK)
    if (PROG_WE) mem[prog_idx] <= PROG_DATA;
`ifdef I_MEM_LAST_BLOCK_EN
  logic lb_valid_q;
  logic [27:0] lb_addr_q;
  logic [127:0] lb_data_q;
  logic [27:0] lb_addr_d;
  logic [29:0] lb_w;
  logic unused_lb;
  assign lb_addr_d = complete ? addr_q : lb_addr_q;
  assign lb_w = {lb_addr_d, 2'b00};
  assign unused_lb = ^{lb_w[29:AW], lb_w[1:0]};
  assign hit = state_q == IDLE && READ && lb_valid_q && ADDRESS == lb_addr_q;
  assign lb_rd = lb_data_q;
  // Invalidation is checked against the block being refilled on this edge, and wins over the refill
  always_ff @(posedge CLK) begin
    if (complete) begin
      lb_addr_q <= addr_q;
      lb_data_q <= blk_rd;
    end
    if (RESET) lb_valid_q <= 1'b0;
    else lb_valid_q <= (PROG_WE && prog_idx[AW-1:2] == lb_w[AW-1:2]) ? 1'b0 : (complete | lb_valid_q);
  end
`else
  assign hit = 1'b0;
  assign lb_rd = '0;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      BUSYWAIT <= 1'b0;
      READDATA <= '0;
      cnt_q <= '0;
      addr_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (hit) begin
            READDATA <= lb_rd;
            state_q <= DONE;
          end else if (READ) begin
            addr_q <= ADDRESS;
            cnt_q <= 8'(LATENCY - 1);
            BUSYWAIT <= 1'b1;
            state_q <= WAIT;
          end
        WAIT:
          if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
          else begin
            READDATA <= blk_rd;
            BUSYWAIT <= 1'b0;
            state_q <= DONE;
          end
        DONE: if (!READ) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i_block_mem.sv
// tb_i_block_mem: directed test-plan checks plus randomized traffic against a transaction-level model.
module tb_i_block_mem;
  localparam int D = 1024;
  localparam int L = 4;
`ifdef I_MEM_LAST_BLOCK_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif
  localparam logic [127:0] BLK4 = 128'h00300193_00200113_00100093_00000013;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic READ = 1'b0;
  logic PROG_WE = 1'b0;
  logic BUSYWAIT;
  logic [27:0] ADDRESS = '0;
  logic [31:0] PROG_ADDR = '0;
  logic [31:0] PROG_DATA = '0;
  logic [127:0] READDATA;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  i_block_mem #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .READ(READ), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA)
  );

  always #5 CLK = ~CLK;

  // Reference: a request accepted at one edge completes L edges later with the memory image of that moment
  logic [31:0] mm [D];
  int busy_left = 0;
  bit done = 1'b0;
  logic [27:0] m_addr = '0;
  logic [127:0] m_data = '0;
  bit lb_v = 1'b0;
  logic [27:0] lb_a = '0;
  logic [127:0] lb_d = '0;

  function automatic int widx(logic [27:0] a, int k);
    logic [29:0] w;
    w = {a, 2'b00};
    return (int'(w) % D) + k;
  endfunction

  function automatic logic [127:0] blk(logic [27:0] a);
    return {mm[widx(a, 3)], mm[widx(a, 2)], mm[widx(a, 1)], mm[widx(a, 0)]};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    int pw;
    @(posedge CLK);
    if (RESET) begin
      busy_left = 0;
      done = 1'b0;
      m_data = '0;
      lb_v = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_data = blk(m_addr);
        done = 1'b1;
        lb_v = 1'b1;
        lb_a = m_addr;
        lb_d = m_data;
      end
    end else if (done) done = READ;
    else if (READ) begin
      if (HIT_EN && lb_v && ADDRESS == lb_a) begin
        m_data = lb_d;
        done = 1'b1;
      end else begin
        m_addr = ADDRESS;
        busy_left = L;
      end
    end
    if (PROG_WE) begin
      pw = int'(PROG_ADDR[31:2]) % D;
      mm[pw] = PROG_DATA;
      if (lb_v && widx(lb_a, 0) / 4 == pw / 4) lb_v = 1'b0;
    end
  end

  always @(negedge CLK) if (chk_en) begin
    chk("model_busywait", BUSYWAIT, busy_left > 0);
    chk("model_readdata", READDATA, m_data);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic prog(logic [31:0] a, logic [31:0] d);
    PROG_WE = 1'b1;
    PROG_ADDR = a;
    PROG_DATA = d;
    tick();
    PROG_WE = 1'b0;
  endtask

  task automatic rst();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) return;
      n++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic req(logic [27:0] a, output int n);
    ADDRESS = a;
    READ = 1'b1;
    tick();
    wait_busy(n);
  endtask

  task automatic drop();
    READ = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("reset_busywait", BUSYWAIT, 0);
    chk("reset_readdata", READDATA, 0);
    for (int i = 0; i < D; i++) prog(32'(i * 4), $urandom);
    prog(32'h40, 32'h00000013);
    prog(32'h44, 32'h00100093);
    prog(32'h48, 32'h00200113);
    prog(32'h4C, 32'h00300193);
    req(28'h4, n);
    chk("first_latency", n, L);
    chk("first_block", READDATA, BLK4);
    drop();
`ifdef I_MEM_LAST_BLOCK_EN
    ADDRESS = 28'h4;
    READ = 1'b1;
    tick();
    @(negedge CLK);
    chk("hit_busywait", BUSYWAIT, 0);
    chk("hit_block", READDATA, BLK4);
    drop();
    prog(32'h44, 32'h0BADF00D);
    req(28'h4, n);
    chk("inval_latency", n, L);
    chk("inval_word1", READDATA[63:32], 32'h0BADF00D);
    drop();
    prog(32'h44, 32'h00100093);
`endif
    rst();
    req(28'h104, n);
    chk("wrap_latency", n, L);
    chk("wrap_block", READDATA, BLK4);
    drop();
    rst();
    ADDRESS = 28'h4;
    READ = 1'b1;
    tick();
    tick();
    tick();
    ADDRESS = 28'h9;
    wait_busy(n);
    chk("addr_change_remaining", n, L - 2);
    chk("addr_change_block", READDATA, BLK4);
    drop();
    rst();
    ADDRESS = 28'h4;
    READ = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk("abort_busywait", BUSYWAIT, 0);
    chk("abort_readdata", READDATA, 0);
    RESET = 1'b0;
    tick();
    wait_busy(n);
    chk("after_abort_latency", n, L);
    chk("after_abort_block", READDATA, BLK4);
    drop();
    rst();
    ADDRESS = 28'h4;
    READ = 1'b1;
    tick();
    prog(32'h48, 32'hDEADBEEF);
    wait_busy(n);
    chk("wait_write_word2", READDATA[95:64], 32'hDEADBEEF);
    drop();
    prog(32'h48, 32'h00200113);
    rst();
    ADDRESS = 28'h4;
    READ = 1'b1;
    tick();
    repeat (L - 1) tick();
    prog(32'h48, 32'hDEADBEEF);
    @(negedge CLK);
    chk("edge_write_busywait", BUSYWAIT, 0);
    chk("edge_write_word2", READDATA[95:64], 32'h00200113);
    drop();
    for (int c = 0; c < 4000; c++) begin
      RESET = $urandom_range(99) == 0;
      if (!BUSYWAIT) READ = $urandom_range(2) != 0;
      case ($urandom_range(3))
        0: ADDRESS = 28'h4;
        1: ADDRESS = 28'h104;
        2: ADDRESS = 28'($urandom_range(7));
        default: ADDRESS = 28'($urandom);
      endcase
      PROG_WE = $urandom_range(4) == 0;
      PROG_ADDR = $urandom_range(1) != 0 ? 32'($urandom_range(127)) : $urandom;
      PROG_DATA = $urandom;
      tick();
    end
    RESET = 1'b0;
    READ = 1'b0;
    PROG_WE = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
